gpio_responder: RTL and testbench

Memory-mapped GPIO peripheral that acts as the responder on the bus driven by the cpu memory stage. It owns the bidirectional gpio pins and provides output, direction, input, edge-interrupt and polarity registers. Bus access uses a single-cycle-latency select/acknowledge handshake. Inputs are synchronized, optionally debounced, and edge-detected into a sticky interrupt status.

---
 rtl/gpio_responder_if.sv | 12 +
 rtl/gpio_responder.sv | 130 +++++++++++++
 tb/tb_gpio_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_responder_if.sv
// Select/acknowledge bus between the cpu memory stage (master) and the gpio responder (slave).
interface gpio_responder_if;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output sel, we, addr, wdata, input rdata, ack);
  modport slave  (input sel, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO responder: OUT/DIR/IN/IE/IS/POL registers, synchronized inputs, sticky edge status.
// Define GPIO_DEBOUNCE_EN to build the per-pin input debouncer.
module gpio_responder #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  gpio_responder_if.slave  bus,
  output logic             irq,
  inout  wire [WIDTH-1:0]  gpio
);

  localparam int unsigned MASK_W    = $clog2(SYNC_STAGES + 2);
  localparam int unsigned MASK_DONE = SYNC_STAGES + 1;

  logic [WIDTH-1:0]  r_out, r_dir, r_ie, r_is, r_pol, r_prev;
  logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [MASK_W-1:0] r_mask_cnt;
  logic              r_ack;
  logic [31:0]       r_rdata;

  logic [WIDTH-1:0]  w_sync_out, w_in, w_event, w_clr, w_wdata;
  logic [31:0]       w_rd_mux;
  logic              w_access, w_wr;
  logic [2:0]        w_idx;
  logic              w_unused_bits;

  assign w_access      = bus.sel & ~r_ack;
  assign w_wr          = w_access & bus.we;
  assign w_idx         = bus.addr[4:2];
  assign w_wdata       = bus.wdata[WIDTH-1:0];
  assign w_sync_out    = r_sync[SYNC_STAGES-1];
  assign w_unused_bits = ^{bus.addr[1:0], bus.wdata};

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign irq       = |(r_ie & r_is);

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_pin
    assign gpio[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] r_in;
  logic [CNT_W-1:0] r_db_cnt [WIDTH];

  // IN follows the synchronizer only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (w_sync_out[i] != r_in[i]) begin
          if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_in[i]     <= w_sync_out[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_in = r_in;
`else
  localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
  assign w_in = w_sync_out;
`endif

  // Edges are ignored until the synchronizer and history have filled after reset
  assign w_event = (r_mask_cnt == MASK_W'(MASK_DONE))
                 ? ((r_pol & r_prev & ~w_in) | (~r_pol & ~r_prev & w_in))
                 : '0;
  assign w_clr   = (w_wr && w_idx == 3'd4) ? w_wdata : '0;

  always_comb begin
    w_rd_mux = '0;
    case (w_idx)
      3'd0:    w_rd_mux = 32'(r_out);
      3'd1:    w_rd_mux = 32'(r_dir);
      3'd2:    w_rd_mux = 32'(w_in);
      3'd3:    w_rd_mux = 32'(r_ie);
      3'd4:    w_rd_mux = 32'(r_is);
      3'd5:    w_rd_mux = 32'(r_pol);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out      <= '0;
      r_dir      <= '0;
      r_ie       <= '0;
      r_is       <= '0;
      r_pol      <= '0;
      r_prev     <= '0;
      r_mask_cnt <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) r_sync[s] <= '0;
    end else begin
      r_ack   <= w_access;
      r_rdata <= (w_access && !bus.we) ? w_rd_mux : '0;
      if (w_wr) begin
        case (w_idx)
          3'd0:    r_out <= w_wdata;
          3'd1:    r_dir <= w_wdata;
          3'd3:    r_ie  <= w_wdata;
          3'd5:    r_pol <= w_wdata;
          default: ;
        endcase
      end
      // a coincident event beats the write-1-to-clear
      r_is   <= (r_is & ~w_clr) | w_event;
      r_prev <= w_in;
      if (r_mask_cnt != MASK_W'(MASK_DONE)) r_mask_cnt <= r_mask_cnt + MASK_W'(1);
      r_sync[0] <= gpio;
      for (int s = 1; s < int'(SYNC_STAGES); s++) r_sync[s] <= r_sync[s-1];
    end
  end

endmodule

// File: tb/tb_gpio_responder.sv
// Table-driven, scoreboarded bench for gpio_responder; honours GPIO_DEBOUNCE_EN for input latency.
module tb_gpio_responder;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned LAT = SYNC + DEB;
`else
  localparam int unsigned LAT = SYNC;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  wire  [31:0] gpio;
  logic [31:0] tb_drv;
  logic [31:0] tb_en;
  logic [31:0] m_out;
  int          total = 0;
  int          bad   = 0;

  gpio_responder_if bus ();

  gpio_responder #(.WIDTH(32), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .irq  (irq),
    .gpio (gpio)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 32; g++) begin : g_drv
    assign gpio[g] = tb_en[g] ? tb_drv[g] : 1'bz;
  end

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } sb_t;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  sb_t  sb [$];
  vec_t vecs [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input string nm);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp = exp; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Called at a negedge with ack low; returns at a negedge with ack low again
  task automatic bus_access(input logic w, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input string nm);
    sb_t e;
    int  cyc;
    e.chk = ~w; e.exp = exp; e.nm = nm;
    sb.push_back(e);
    bus.sel = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack !== 1'b1 && cyc < 8);
    check({nm, "_ack_lat"}, 32'(cyc), 32'd1);
    if (bus.ack !== 1'b1) sb.delete();
    bus.sel = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard consumer: each ack retires the oldest outstanding access
  always @(negedge clk) begin : mon
    sb_t e;
    if (bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        e = sb.pop_front();
        if (e.chk) check(e.nm, bus.rdata, e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    tb_drv = '0; tb_en = '1; m_out = '0;

    add_vec(0, 5'h00, 0, 32'h0, "rd_out_rst");
    add_vec(0, 5'h04, 0, 32'h0, "rd_dir_rst");
    add_vec(0, 5'h08, 0, 32'h0, "rd_in_rst");
    add_vec(0, 5'h0C, 0, 32'h0, "rd_ie_rst");
    add_vec(0, 5'h10, 0, 32'h0, "rd_is_rst");
    add_vec(0, 5'h14, 0, 32'h0, "rd_pol_rst");
    add_vec(1, 5'h04, 32'h0000_00FF, 0, "wr_dir");
    add_vec(1, 5'h00, 32'hA5A5_A5A5, 0, "wr_out");
    add_vec(0, 5'h00, 0, 32'hA5A5_A5A5, "rd_out");
    add_vec(0, 5'h04, 0, 32'h0000_00FF, "rd_dir");
    add_vec(0, 5'h1C, 0, 32'h0, "rd_unmapped_1c");
    add_vec(0, 5'h18, 0, 32'h0, "rd_unmapped_18");
    add_vec(1, 5'h0C, 32'h0000_0100, 0, "wr_ie");
    add_vec(0, 5'h0C, 0, 32'h0000_0100, "rd_ie");
    add_vec(1, 5'h14, 32'h0000_0200, 0, "wr_pol");
    add_vec(0, 5'h14, 0, 32'h0000_0200, "rd_pol");
    add_vec(1, 5'h08, 32'hFFFF_FFFF, 0, "wr_in_ignored");
    add_vec(0, 5'h08, 0, 32'h0000_00A5, "rd_in_outputs");
    add_vec(0, 5'h10, 0, 32'h0000_00A5, "rd_is_output_edges");
    add_vec(1, 5'h10, 32'h0000_00A5, 0, "clr_is");
    add_vec(0, 5'h10, 0, 32'h0, "rd_is_cleared");

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_gpio", gpio, tb_drv);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      bus_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].nm);
      if (vecs[i].w && vecs[i].a == 5'h04) tb_en = ~vecs[i].d;
      if (vecs[i].w && vecs[i].a == 5'h00) m_out = vecs[i].d;
      if (vecs[i].w && (vecs[i].a == 5'h00 || vecs[i].a == 5'h04)) begin
        check({vecs[i].nm, "_gpio"}, gpio, (m_out & ~tb_en) | (tb_drv & tb_en));
        repeat (LAT + 2) @(negedge clk);
      end
    end
    check("irq_no_enabled_bits", 32'(irq), 32'd0);

    // rising edge on pin 8 with IE enabled
    tb_drv[8] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (irq !== 1'b1 && cyc < 40);
    check("irq_rise_cycles", 32'(cyc), 32'(LAT + 1));
    bus_access(0, 5'h10, 0, 32'h0000_0100, "rd_is_pin8");
    bus_access(1, 5'h10, 32'h0000_0100, 0, "clr_is_pin8");
    bus_access(0, 5'h10, 0, 32'h0, "rd_is_pin8_clr");
    check("irq_after_clr", 32'(irq), 32'd0);

    // falling-edge polarity on pin 9; event coincides with a clear of the same bit
    tb_drv[9] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    bus_access(0, 5'h10, 0, 32'h0, "rd_is_pol_rise_ignored");
    tb_drv[9] = 1'b0;
    repeat (LAT) @(negedge clk);
    bus_access(1, 5'h10, 32'h0000_0200, 0, "clr_is_race");
    bus_access(0, 5'h10, 0, 32'h0000_0200, "rd_is_set_wins");
    bus_access(1, 5'h10, 32'h0000_0200, 0, "clr_is_pin9");
    bus_access(0, 5'h10, 0, 32'h0, "rd_is_pin9_clr");

    // sel held high: a new access every other cycle
    for (int k = 0; k < 3; k++) begin
      sb_t e;
      e.chk = 1'b1; e.exp = (tb_drv & tb_en) | (m_out & ~tb_en); e.nm = "hold_rd_in";
      sb.push_back(e);
    end
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 5'h08;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("hold_ack_%0d", k), 32'(bus.ack), 32'(k % 2));
    end
    bus.sel = 1'b0;
    @(negedge clk);

    // reset during a pending write; pin 8 held high across reset release
    tb_drv = '0;
`ifndef GPIO_DEBOUNCE_EN
    tb_drv[8] = 1'b1;
`endif
    tb_en = '1; m_out = '0;
    rst = 1'b0;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 5'h00; bus.wdata = 32'h1234_5678;
    @(negedge clk);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_gpio", gpio, tb_drv);
    bus.sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    bus_access(0, 5'h00, 0, 32'h0, "rd_out_after_midrst");
    bus_access(0, 5'h04, 0, 32'h0, "rd_dir_after_midrst");
    bus_access(0, 5'h0C, 0, 32'h0, "rd_ie_after_midrst");
    bus_access(0, 5'h14, 0, 32'h0, "rd_pol_after_midrst");
    bus_access(0, 5'h10, 0, 32'h0, "rd_is_no_false_edge");
    bus_access(0, 5'h08, 0, tb_drv, "rd_in_after_midrst");

    // IN latency bracketed on pin 3: old value one cycle early, new value exactly on time
    tb_drv[3] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    bus_access(0, 5'h08, 0, tb_drv & ~32'h8, "in_before_lat");
    repeat (LAT + 5) @(negedge clk);
    tb_drv[3] = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    tb_drv[3] = 1'b1;
    repeat (LAT) @(negedge clk);
    bus_access(0, 5'h08, 0, tb_drv, "in_at_lat");

`ifdef GPIO_DEBOUNCE_EN
    // a 10-cycle glitch is filtered out completely
    tb_drv[3] = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    bus_access(1, 5'h10, 32'hFFFF_FFFF, 0, "clr_is_all");
    tb_drv[3] = 1'b1;
    repeat (10) @(negedge clk);
    tb_drv[3] = 1'b0;
    repeat (40) @(negedge clk);
    bus_access(0, 5'h08, 0, tb_drv, "in_glitch_filtered");
    bus_access(0, 5'h10, 0, 32'h0, "is_glitch_filtered");
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
